// File: rtl/rv32i_control_unit_if.sv
// rv32i_control_unit_if: signal bundle between the control unit and the dataflow block / RAM.
interface rv32i_control_unit_if;
    logic [31:0] insn;
    logic        EQ, LS, LU;
    logic        insn_clk, pc_clk, rd_clk;
    logic        pc_next_sel, pc_alu_sel, alu_sel_a, alu_sel_b, addr_sel, sub_sra;
    logic [1:0]  rd_sel;
    logic [2:0]  func, mem_size;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        mem_rd, mem_wr, illegal;
    modport master (
        input  insn, EQ, LS, LU,
        output insn_clk, pc_clk, rd_clk, pc_next_sel, pc_alu_sel, alu_sel_a, alu_sel_b,
               addr_sel, sub_sra, rd_sel, func, mem_size, rs1, rs2, rd, imm,
               mem_rd, mem_wr, illegal
    );
    modport slave (
        output insn, EQ, LS, LU,
        input  insn_clk, pc_clk, rd_clk, pc_next_sel, pc_alu_sel, alu_sel_a, alu_sel_b,
               addr_sel, sub_sra, rd_sel, func, mem_size, rs1, rs2, rd, imm,
               mem_rd, mem_wr, illegal
    );
endinterface

// File: rtl/rv32i_control_unit.sv
// rv32i_control_unit: one-hot multi-cycle sequencer and instruction decoder for the RV32I dataflow block.
module rv32i_control_unit (
    input logic                  clk,
    input logic                  reset,
    rv32i_control_unit_if.master bus
);
    typedef enum logic [5:0] {
        FETCH  = 6'b000001,
        DECODE = 6'b000010,
        EXEC   = 6'b000100,
        MEM    = 6'b001000,
        WB     = 6'b010000,
        TRAP   = 6'b100000
    } state_t;
    state_t state;
    logic [31:0] i;
    logic [2:0]  f3;
    logic        is_op, is_opi, is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st;
    logic        legal, taken, writes;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    assign i        = bus.insn;
    assign f3       = i[14:12];
    assign is_op    = i[6:0] == 7'b0110011;
    assign is_opi   = i[6:0] == 7'b0010011;
    assign is_lui   = i[6:0] == 7'b0110111;
    assign is_auipc = i[6:0] == 7'b0010111;
    assign is_jal   = i[6:0] == 7'b1101111;
    assign is_jalr  = i[6:0] == 7'b1100111;
    assign is_br    = i[6:0] == 7'b1100011;
    assign is_ld    = i[6:0] == 7'b0000011;
    assign is_st    = i[6:0] == 7'b0100011;
    // funct3 holes: branch 01x, load 011/11x, store 011/1xx
    assign legal = is_op | is_opi | is_lui | is_auipc | is_jal
                 | (is_jalr & f3 == 3'b000)
                 | (is_br & f3[2:1] != 2'b01)
                 | (is_ld & f3[1:0] != 2'b11 & f3[2:1] != 2'b11)
                 | (is_st & !f3[2] & f3[1:0] != 2'b11);
    assign writes = is_op | is_opi | is_lui | is_auipc | is_jal | is_jalr | is_ld;
    assign taken  = f3[2:1] == 2'b00 ? bus.EQ ^ f3[0] :
                    f3[2:1] == 2'b10 ? bus.LS ^ f3[0] : bus.LU ^ f3[0];
    assign i_imm = {{20{i[31]}}, i[31:20]};
    assign s_imm = {{20{i[31]}}, i[31:25], i[11:7]};
    assign b_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    assign u_imm = {i[31:12], 12'b0};
    assign j_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    always_ff @(posedge clk)
        if (reset) state <= FETCH;
        else case (state)
            FETCH:   state <= DECODE;
            DECODE:  state <= legal ? EXEC : TRAP;
            EXEC:    state <= (is_ld | is_st) ? MEM : WB;
            MEM:     state <= WB;
            WB:      state <= FETCH;
            TRAP:    state <= TRAP;
            default: state <= FETCH;
        endcase
    assign bus.insn_clk    = state == DECODE;
    assign bus.pc_clk      = state == WB;
    assign bus.rd_clk      = state == WB && writes;
    assign bus.illegal     = state == TRAP;
    assign bus.mem_rd      = state == FETCH || (state == MEM && is_ld);
    assign bus.mem_wr      = state == MEM && is_st;
    assign bus.addr_sel    = state == MEM || (state == WB && is_ld);
    assign bus.rs1         = i[19:15];
    assign bus.rs2         = i[24:20];
    assign bus.rd          = i[11:7];
    assign bus.alu_sel_a   = is_auipc | is_jal;
    assign bus.alu_sel_b   = is_opi | is_auipc | is_jal | is_jalr | is_ld | is_st;
    assign bus.func        = (is_op | is_opi) ? f3 : 3'b000;
    assign bus.sub_sra     = (is_op & i[30]) | (is_opi & i[30] & f3 == 3'b101);
    assign bus.rd_sel      = is_lui ? 2'd1 : (is_op | is_opi | is_auipc) ? 2'd2 : (is_jal | is_jalr) ? 2'd3 : 2'd0;
    assign bus.pc_next_sel = is_jal | is_jalr;
    assign bus.pc_alu_sel  = is_br & taken;
    assign bus.mem_size    = (is_ld | is_st) ? f3 : 3'b000;
    assign bus.imm         = (is_lui | is_auipc) ? u_imm :
                             is_jal ? j_imm :
                             is_br ? b_imm :
                             is_st ? s_imm :
                             (is_opi | is_jalr | is_ld) ? i_imm : 32'b0;
endmodule
